// File: rtl/id_ex_forward.sv
// ID/EX pipeline register plus execute-stage operand forwarding.
// Holds the decoded instruction for one cycle. Resolves EX/MEM and MEM/WB
// bypasses into the ALU A/B operands and the store data. Also flags a
// load-use dependency against the instruction currently in ID.
module id_ex_forward #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic [WIDTH-1:0] id_rs_data,
  input  logic [WIDTH-1:0] id_rt_data,
  input  logic [WIDTH-1:0] id_imm,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_rd,
  input  logic [2:0]       id_alu_op,
  input  logic             id_alu_src,
  input  logic             id_reg_dst,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             id_mem_to_reg,
  input  logic             id_branch,
  input  logic             exmem_reg_write,
  input  logic [4:0]       exmem_rd,
  input  logic [WIDTH-1:0] exmem_result,
  input  logic             memwb_reg_write,
  input  logic [4:0]       memwb_rd,
  input  logic [WIDTH-1:0] memwb_result,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  output logic [WIDTH-1:0] ex_store_data,
  output logic [4:0]       ex_write_reg,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_mem_to_reg,
  output logic             ex_branch,
  output logic [4:0]       ex_rs,
  output logic [4:0]       ex_rt,
  output logic             load_use_hazard
);

  typedef struct packed {
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic [WIDTH-1:0] imm;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic [4:0]       rd;
    logic [2:0]       alu_op;
    logic             alu_src;
    logic             reg_dst;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             mem_to_reg;
    logic             branch;
  } idex_t;

  idex_t d, q;
  logic [WIDTH-1:0] fwd_rs, fwd_rt;

  // Gather the ID-stage fields into one bundle for the pipeline register.
  always_comb begin
    d            = '0;
    d.rs_data    = id_rs_data;
    d.rt_data    = id_rt_data;
    d.imm        = id_imm;
    d.rs         = id_rs;
    d.rt         = id_rt;
    d.rd         = id_rd;
    d.alu_op     = id_alu_op;
    d.alu_src    = id_alu_src;
    d.reg_dst    = id_reg_dst;
    d.reg_write  = id_reg_write;
    d.mem_read   = id_mem_read;
    d.mem_write  = id_mem_write;
    d.mem_to_reg = id_mem_to_reg;
    d.branch     = id_branch;
  end

  // Pipeline register: reset and flush both insert an all-zero bubble.
  // Flush beats stall so the hazard unit can assert both together.
  always_ff @(posedge clk) begin
    if (!rst_n)      q <= '0;
    else if (flush)  q <= '0;
    else if (!stall) q <= d;
  end

  // Bypass muxes: the younger EX/MEM result wins over MEM/WB.
  // $zero is never bypassed because it must always read as its file value.
  always_comb begin
    fwd_rs = q.rs_data;
    if (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == q.rs)
      fwd_rs = exmem_result;
    else if (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == q.rs)
      fwd_rs = memwb_result;

    fwd_rt = q.rt_data;
    if (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == q.rt)
      fwd_rt = exmem_result;
    else if (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == q.rt)
      fwd_rt = memwb_result;
  end

  assign alu_a         = fwd_rs;
  assign alu_b         = q.alu_src ? q.imm : fwd_rt;
  assign ex_store_data = fwd_rt;
  assign alu_op        = q.alu_op;
  assign ex_write_reg  = q.reg_dst ? q.rd : q.rt;
  assign ex_reg_write  = q.reg_write;
  assign ex_mem_read   = q.mem_read;
  assign ex_mem_write  = q.mem_write;
  assign ex_mem_to_reg = q.mem_to_reg;
  assign ex_branch     = q.branch;
  assign ex_rs         = q.rs;
  assign ex_rt         = q.rt;

  // A load in EX whose destination is read by the instruction in ID
  // cannot be bypassed in time, so it must be flagged for a stall.
  assign load_use_hazard = q.mem_read && ex_write_reg != 5'd0 &&
                           (ex_write_reg == id_rs || ex_write_reg == id_rt);

endmodule

// File: tb/tb_id_ex_forward.sv
// Bench for id_ex_forward: a reference model of the ID/EX contents plus
// forwarding rules, checked every cycle, and directed literal expectations.
module tb_id_ex_forward;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n, stall, flush;
  logic [W-1:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0] id_rs, id_rt, id_rd;
  logic [2:0] id_alu_op;
  logic id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch;
  logic exmem_reg_write, memwb_reg_write;
  logic [4:0] exmem_rd, memwb_rd;
  logic [W-1:0] exmem_result, memwb_result;
  logic [W-1:0] alu_a, alu_b, ex_store_data;
  logic [2:0] alu_op;
  logic [4:0] ex_write_reg, ex_rs, ex_rt;
  logic ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch, load_use_hazard;

  id_ex_forward #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_alu_op(id_alu_op),
    .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .ex_store_data(ex_store_data),
    .ex_write_reg(ex_write_reg), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .load_use_hazard(load_use_hazard)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model of what the execute stage holds: one instruction record.
  typedef struct {
    logic [31:0] rs_data, rt_data, imm;
    logic [4:0] rs, rt, rd;
    logic [2:0] op;
    logic src, dst, rw, mr, mw, m2r, br;
  } instr_t;
  instr_t m;

  // Value of register `spec` as seen in EX: youngest in-flight writer first,
  // with $zero never overridden.
  function automatic logic [31:0] reg_value(input logic [4:0] spec, input logic [31:0] file_val);
    logic [4:0] wr_rd [2];
    logic wr_en [2];
    logic [31:0] wr_val [2];
    wr_rd[0] = exmem_rd; wr_en[0] = exmem_reg_write; wr_val[0] = exmem_result;
    wr_rd[1] = memwb_rd; wr_en[1] = memwb_reg_write; wr_val[1] = memwb_result;
    if (spec == 0) return file_val;
    for (int k = 0; k < 2; k++)
      if (wr_en[k] && wr_rd[k] == spec) return wr_val[k];
    return file_val;
  endfunction

  // Advance the model one pipeline step.
  always @(posedge clk) begin
    if (!rst_n || flush) m = '{default: '0};
    else if (!stall) begin
      m.rs_data = id_rs_data; m.rt_data = id_rt_data; m.imm = id_imm;
      m.rs = id_rs; m.rt = id_rt; m.rd = id_rd; m.op = id_alu_op;
      m.src = id_alu_src; m.dst = id_reg_dst; m.rw = id_reg_write; m.mr = id_mem_read;
      m.mw = id_mem_write; m.m2r = id_mem_to_reg; m.br = id_branch;
    end
  end

  // Compare every cycle, mid-period.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [4:0] dest;
      logic [31:0] rtv;
      dest = m.dst ? m.rd : m.rt;
      rtv = reg_value(m.rt, m.rt_data);
      chk("m_alu_a", alu_a, reg_value(m.rs, m.rs_data));
      chk("m_alu_b", alu_b, m.src ? m.imm : rtv);
      chk("m_store", ex_store_data, rtv);
      chk("m_alu_op", 32'(alu_op), 32'(m.op));
      chk("m_write_reg", 32'(ex_write_reg), 32'(dest));
      chk("m_ctrl", {27'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch},
          {27'd0, m.rw, m.mr, m.mw, m.m2r, m.br});
      chk("m_specs", {22'd0, ex_rs, ex_rt}, {22'd0, m.rs, m.rt});
      chk("m_hazard", 32'(load_use_hazard),
          32'(m.mr && dest != 0 && (dest == id_rs || dest == id_rt)));
    end
  end

  task automatic clear_id();
    id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_rs = 0; id_rt = 0; id_rd = 0;
    id_alu_op = 0; id_alu_src = 0; id_reg_dst = 0; id_reg_write = 0; id_mem_read = 0;
    id_mem_write = 0; id_mem_to_reg = 0; id_branch = 0;
  endtask

  initial begin
    m = '{default: '0};
    rst_n = 0; stall = 0; flush = 0;
    exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
    id_rs_data = 32'hDEAD_BEEF; id_rt_data = 32'h1234_5678; id_imm = 32'h0000_00FF;
    id_rs = 5; id_rt = 6; id_rd = 9; id_alu_op = 3'b111;
    id_alu_src = 1; id_reg_dst = 1; id_reg_write = 1; id_mem_read = 1;
    id_mem_write = 1; id_mem_to_reg = 1; id_branch = 1;

    // Reset held two edges with busy inputs.
    repeat (2) @(posedge clk);
    #1 chk_en = 1;
    @(negedge clk);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_op", 32'(alu_op), 0);
    chk("rst_wreg", 32'(ex_write_reg), 0);
    chk("rst_ctrl", {27'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch}, 0);
    chk("rst_hazard", 32'(load_use_hazard), 0);

    // Plain load, no forwarding.
    #1 rst_n = 1; clear_id();
    id_rs_data = 5; id_rt_data = 3; id_alu_op = 3'b010; id_rs = 1; id_rt = 2; id_rd = 3;
    id_reg_write = 1; id_reg_dst = 1;
    @(negedge clk);
    chk("plain_a", alu_a, 5);
    chk("plain_b", alu_b, 3);
    chk("plain_op", 32'(alu_op), 2);
    chk("plain_wreg", 32'(ex_write_reg), 3);

    // Forward priority, then drop EX/MEM while held.
    #1 id_rs = 4; id_rs_data = 32'h1111;
    exmem_reg_write = 1; exmem_rd = 4; exmem_result = 32'hAAAA_0000;
    memwb_reg_write = 1; memwb_rd = 4; memwb_result = 32'h5555_0000;
    @(negedge clk);
    chk("prio_exmem", alu_a, 32'hAAAA_0000);
    #1 exmem_reg_write = 0; stall = 1;
    @(negedge clk);
    chk("prio_memwb", alu_a, 32'h5555_0000);

    // Register zero never forwarded.
    #1 stall = 0; id_rs = 0; id_rs_data = 0;
    exmem_reg_write = 1; exmem_rd = 0; exmem_result = 32'hFFFF_FFFF; memwb_reg_write = 0;
    @(negedge clk);
    chk("zero_reg", alu_a, 0);

    // Immediate operand and forwarded store data.
    #1 exmem_reg_write = 0; id_alu_src = 1; id_imm = 32'hFFFF_FFF8; id_rt = 3; id_rt_data = 32'h99;
    memwb_reg_write = 1; memwb_rd = 3; memwb_result = 32'h1234;
    @(negedge clk);
    chk("imm_b", alu_b, 32'hFFFF_FFF8);
    chk("store_fwd", ex_store_data, 32'h1234);

    // Load-use hazard, then stall+flush together.
    #1 memwb_reg_write = 0; clear_id();
    id_mem_read = 1; id_reg_write = 1; id_mem_to_reg = 1; id_rt = 7; id_rd = 12; id_rs = 1;
    @(negedge clk);
    #1 clear_id(); id_rs = 7; id_rt = 2;
    #1 chk("lu_hazard", 32'(load_use_hazard), 1);
    stall = 1; flush = 1;
    @(negedge clk);
    chk("flush_ctrl", {27'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch}, 0);
    chk("flush_hazard", 32'(load_use_hazard), 0);

    // Stall alone holds across three edges while ID keeps changing.
    #1 stall = 0; flush = 0;
    id_rs = 8; id_rt = 9; id_rd = 10; id_reg_dst = 1; id_rs_data = 32'hCAFE; id_rt_data = 32'hBEEF;
    id_alu_op = 3'b110; id_branch = 1; id_mem_write = 1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      #1 stall = 1; id_rs = 5'(i + 13); id_rd = 5'(i + 20); id_alu_op = 3'(i); id_rs_data = 32'(i);
      @(negedge clk);
      chk("hold_wreg", 32'(ex_write_reg), 10);
      chk("hold_op", 32'(alu_op), 6);
      chk("hold_a", alu_a, 32'hCAFE);
    end
    // A held instruction still sees a new bypass value.
    #1 exmem_reg_write = 1; exmem_rd = 8; exmem_result = 32'h77;
    @(negedge clk);
    chk("hold_fwd", alu_a, 32'h77);

    // Reset mid-stream beats stall.
    #1 rst_n = 0; exmem_reg_write = 0;
    @(negedge clk);
    chk("midrst_op", 32'(alu_op), 0);
    chk("midrst_wreg", 32'(ex_write_reg), 0);

    // Directed sweep over small specifiers so bypass matches are frequent.
    #1 rst_n = 1; stall = 0;
    for (int i = 0; i < 48; i++) begin
      id_rs = 5'(i % 4); id_rt = 5'((i / 4) % 4); id_rd = 5'((i * 3) % 4);
      id_rs_data = 32'h100 + 32'(i); id_rt_data = 32'h200 + 32'(i); id_imm = 32'h300 + 32'(i);
      id_alu_op = 3'(i); id_alu_src = i[1]; id_reg_dst = i[2]; id_reg_write = i[0];
      id_mem_read = i[3]; id_mem_write = i[4]; id_mem_to_reg = i[3]; id_branch = i[5];
      exmem_reg_write = i[0] ^ i[2]; exmem_rd = 5'((i + 1) % 4); exmem_result = 32'hE000 + 32'(i);
      memwb_reg_write = i[1] | i[3]; memwb_rd = 5'((i + 2) % 4); memwb_result = 32'hB000 + 32'(i);
      stall = (i % 7 == 3); flush = (i % 11 == 5);
      @(negedge clk);
      #1;
    end

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_forward.md
# id_ex_forward

ID/EX pipeline register and execute-stage operand selector for the 5-stage MIPS pipeline. It captures decoded operands and control from ID each cycle and resolves EX/MEM and MEM/WB forwarding into the final ALU A/B operands and the 3-bit ALU operation. It also produces the store-data operand and the load-use hazard flag consumed by the hazard/stall logic. Output sits directly upstream of the ALU's A, B and ALUoperation inputs.

## Interface
- WIDTH, 32, datapath width
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low
- stall  in  1  hold all ID/EX registers
- flush  in  1  load a bubble into ID/EX
- id_rs_data, id_rt_data  in  WIDTH  register-file read data
- id_imm  in  WIDTH  sign-extended immediate
- id_rs, id_rt, id_rd  in  5  register specifiers
- id_alu_op  in  3  ALU operation code (000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT)
- id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch  in  1 each  decoded control
- exmem_reg_write  in  1, exmem_rd  in  5, exmem_result  in  WIDTH  EX/MEM writeback source
- memwb_reg_write  in  1, memwb_rd  in  5, memwb_result  in  WIDTH  MEM/WB writeback source
- alu_a, alu_b  out  WIDTH  forwarded ALU operands
- alu_op  out  3  registered ALU operation
- ex_store_data  out  WIDTH  forwarded rt value for stores
- ex_write_reg  out  5  destination (rd if reg_dst else rt)
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch  out  1 each  registered control
- ex_rs, ex_rt  out  5  registered specifiers
- load_use_hazard  out  1  ID instruction needs a load result still in EX

## Operation
- Registers: all id_* fields captured into ex_* on each rising edge.
- Priority per edge: !rst_n > flush > stall > load.
  - Reset/flush: every register cleared to 0 (bubble: all control 0, alu_op 000, specifiers 0, data 0).
  - Stall: every register holds its value.
  - Otherwise: load id_* values.
- Forward select, per source operand (rs → A path, rt → B/store path), combinational from registered specifiers:
  - EX/MEM if exmem_reg_write && exmem_rd != 0 && exmem_rd == spec.
  - else MEM/WB if memwb_reg_write && memwb_rd != 0 && memwb_rd == spec.
  - else registered register-file data.
  - EX/MEM always beats MEM/WB when both match. Register 0 is never forwarded.
- alu_a = forwarded rs value.
- ex_store_data = forwarded rt value.
- alu_b = ex_imm if ex_alu_src, else forwarded rt value.
- ex_write_reg = ex_reg_dst ? ex_rd : ex_rt.
- load_use_hazard (combinational) = ex_mem_read && ex_write_reg != 0 && (ex_write_reg == id_rs || ex_write_reg == id_rt).
  - The hazard unit uses it to stall IF/ID and assert flush here in the same cycle.
- Width rules: no arithmetic here. All data paths are WIDTH bits and pass through unmodified.

## Timing
- Latency: id_* → ex_* in exactly one cycle. Forward muxes add zero cycles, so alu_a/alu_b are valid in the same cycle as the registered fields.
- Reset values: all ex_* outputs, alu_op, ex_write_reg = 0. alu_a = alu_b = ex_store_data = 0, provided forward sources are deasserted. load_use_hazard = 0.
- Forwarding is recomputed every cycle, including stalled cycles. A held instruction picks up newer EX/MEM/MEM-WB values as they change.
- Simultaneous stall and flush: flush wins.
- Reset asserted mid-stream: the next edge clears to bubble regardless of stall/flush.
- A bubble (ex_reg_write=0, ex_mem_read=0) never raises load_use_hazard.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with id_* nonzero → every output 0. Release: first load appears one edge later.
- Plain load, no forwarding:
  - Stimulus: id_rs_data=0x0000_0005, id_rt_data=0x0000_0003, id_alu_op=010, alu_src=0, rs=1, rt=2, no writeback matches.
  - Required: next cycle alu_a=5, alu_b=3, alu_op=010.
- Forward priority:
  - Stimulus: ex_rs=4, exmem_rd=4 with result 0xAAAA_0000, memwb_rd=4 with result 0x5555_0000, both write-enabled.
  - Required: alu_a=0xAAAA_0000. Drop exmem_reg_write → alu_a=0x5555_0000.
- Register zero: ex_rs=0, exmem_rd=0, exmem_reg_write=1, exmem_result=0xFFFF_FFFF → alu_a = registered rs data (0), not forwarded.
- Immediate/store path:
  - Stimulus: alu_src=1, id_imm=0xFFFF_FFF8, rt=3 matching memwb_rd=3 with result 0x1234.
  - Required: alu_b=0xFFFF_FFF8, ex_store_data=0x1234.
- Load-use and stall/flush:
  - Stimulus: ex_mem_read=1, ex_write_reg(rt)=7, id_rs=7.
  - Required: load_use_hazard=1. Assert stall and flush together → next cycle all control 0, load_use_hazard=0. Stall alone → registers unchanged across 3 edges.
